item_memory_seq: RTL and testbench
==================================

Name: item_memory_seq

Overview:
Multi-port, sequential successor to the combinational CiM/CA90 item memory.
- Generates item HVs by iterating the CA90 rule from internally stored seeds, a configurable number of steps per cycle. This removes the full per-item unrolled CA90 logic.
- Also generates CiM level HVs and zero HVs.
- Each of NumPorts independent read ports has a valid/ready request channel and a valid/ready response channel.
- Sits between the encoder datapath and seed configuration registers.

Parameters:
- HVDimension, 512, HV width in bits; multiple of SeedWidth.
- NumTotIm, 1024, total item HVs addressable.
- NumPerImBank, 128, items per seed bank.
- SeedWidth, 32, seed width.
- NumPorts, 2, independent read ports.
- UnrollFactor, 4, CA90 steps applied per cycle; >=1.
- ImAddrWidth, $clog2(NumTotIm), derived.
- NumImSets, NumTotIm/NumPerImBank, derived.
- SeedAddrWidth, $clog2(NumImSets+1), derived.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- seed_wr_valid_i  in  1  seed write request
- seed_wr_ready_o  out  1  seed write accepted
- seed_wr_addr_i  in  SeedAddrWidth  0..NumImSets-1 = IM bank seed; NumImSets = CiM seed
- seed_wr_data_i  in  SeedWidth  seed value
- req_valid_i  in  [NumPorts]  request valid per port
- req_ready_o  out  [NumPorts]  request ready per port
- req_mode_i  in  [NumPorts][2]  0=IM, 1=CiM, 2=zero, 3=reserved
- req_addr_i  in  [NumPorts][ImAddrWidth]  item index or CiM level
- rsp_valid_o  out  [NumPorts]  response valid
- rsp_ready_i  in  [NumPorts]  response consumed
- rsp_hv_o  out  [NumPorts][HVDimension]  response HV
- rsp_err_o  out  [NumPorts]  response flagged illegal

Behaviour:
Clock and reset: single clock clk_i; rst_ni is asynchronous, active-low.

Reset:
- All seeds = 0.
- All ports enter IDLE.
- req_ready_o = all 1 once out of reset.
- rsp_valid_o = 0, rsp_hv_o = 0, rsp_err_o = 0.
- Reset mid-generation aborts the operation with no response.

Seed write:
- seed_wr_ready_o = 1 only when every port is in IDLE.
- Write occurs on valid&&ready.
- Addresses > NumImSets are ignored but still handshaken.
- A request accepted in the same cycle as a seed write uses the pre-write seed.

Expansion: E(s) = s replicated HVDimension/SeedWidth times; seed bit 0 maps to HV bit 0.

CA90 step: next[i] = cur[(i-1) mod D] XOR cur[(i+1) mod D], with D = HVDimension.

IM item a:
- bank = a / NumPerImBank, k = a % NumPerImBank.
- HV = CA90^k(E(seed[bank])).

CiM level L:
- L = req_addr_i[CimSelWidth-1:0], with CimSelWidth = $clog2(HVDimension/2); upper address bits are ignored.
- HV = E(cim_seed) XOR mask, where mask has bits [2L-1:0] set.
- L=0 gives E(cim_seed) unchanged.

Zero mode: HV = 0.

Errors:
- Mode 3, or IM with a >= NumTotIm, produces HV = 0 and rsp_err_o = 1.

Per-port FSM:
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, capture mode and addr, load state register, set remaining = k (IM) or 0 (otherwise), go to GEN.
- GEN:
  - Each cycle apply min(UnrollFactor, remaining) CA90 steps and decrement remaining by that amount.
  - When remaining == 0 at the start of a cycle, register HV/err into rsp_*_o and go to RESP.
  - CiM, zero and error requests spend exactly one cycle in GEN.
- RESP:
  - rsp_valid_o = 1; rsp_hv_o and rsp_err_o are held stable.
  - On rsp_ready_i, go to IDLE with rsp_valid_o = 0.
  - A new request is not accepted in the same cycle as the response handshake.

Latency: request accepted at cycle t gives rsp_valid_o at t+1+ceil(k/UnrollFactor) for IM, and t+1 for all other modes.

Port independence: ports share seeds only. There are no structural hazards between ports, and simultaneous requests on all ports proceed in parallel.

Backpressure: rsp_valid_o stays high indefinitely while rsp_ready_i = 0; the port accepts nothing meanwhile.

Test Plan (HVDimension=512, SeedWidth=32, NumPerImBank=128, UnrollFactor=4):
- Reset, then write seed bank0 = 0x00000001. Port0 IM addr 0 -> rsp_valid at t+1; HV bits set exactly at 0,32,...,480; err=0.
- Same seed, port0 IM addr 1 -> HV bits set at 1,31,33,63,...,479,481,511; rsp at t+2. IM addr 5 -> rsp at t+3 and HV equal to the model's CA90^5.
- Write CiM seed 0xFFFFFFFF; CiM level 3 -> HV bits [5:0] = 0, rest 1; rsp at t+1. Mode 2 -> HV all 0.
- Port0 IM addr 127 and port1 IM addr 128 (bank1 seed 0x80000000) issued same cycle -> port0 rsp at t+33, port1 rsp at t+1 equal to E(0x80000000). Seed write attempted during the port0 GEN phase sees seed_wr_ready_o = 0 until both ports are back in IDLE.
- Mode 3 -> err=1, HV=0. With NumTotIm=1000, IM addr 1000 -> err=1.
- Hold rsp_ready_i = 0 for 10 cycles -> rsp held stable, req_ready_o = 0. Assert rst_ni = 0 during GEN -> rsp_valid_o = 0 and all seeds 0 immediately.

Source files
------------

// File: rtl/item_memory_seq.sv
// rtl/item_memory_seq.sv - multi-port sequential CA90/CiM item memory
// Each port walks CA90 from a stored seed at UnrollFactor steps per cycle.
module item_memory_seq #(
  parameter int unsigned HVDimension   = 512,
  parameter int unsigned NumTotIm      = 1024,
  parameter int unsigned NumPerImBank  = 128,
  parameter int unsigned SeedWidth     = 32,
  parameter int unsigned NumPorts      = 2,
  parameter int unsigned UnrollFactor  = 4,
  parameter int unsigned ImAddrWidth   = $clog2(NumTotIm),
  parameter int unsigned NumImSets     = NumTotIm / NumPerImBank,
  parameter int unsigned SeedAddrWidth = $clog2(NumImSets + 1)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic                                    seed_wr_valid_i,
  output logic                                    seed_wr_ready_o,
  input  logic [SeedAddrWidth-1:0]                seed_wr_addr_i,
  input  logic [SeedWidth-1:0]                    seed_wr_data_i,
  input  logic [NumPorts-1:0]                     req_valid_i,
  output logic [NumPorts-1:0]                     req_ready_o,
  input  logic [NumPorts-1:0][1:0]                req_mode_i,
  input  logic [NumPorts-1:0][ImAddrWidth-1:0]    req_addr_i,
  output logic [NumPorts-1:0]                     rsp_valid_o,
  input  logic [NumPorts-1:0]                     rsp_ready_i,
  output logic [NumPorts-1:0][HVDimension-1:0]    rsp_hv_o,
  output logic [NumPorts-1:0]                     rsp_err_o
);

  localparam int unsigned NumReps     = HVDimension / SeedWidth;
  localparam int unsigned CimSelWidth = $clog2(HVDimension / 2);
  localparam int unsigned RemWidth    = $clog2(NumPerImBank + 1);
  localparam int unsigned StepWidth   = $clog2(UnrollFactor + 1);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_RESP} state_e;

  function automatic logic [HVDimension-1:0] expand(input logic [SeedWidth-1:0] s);
    logic [HVDimension-1:0] e;
    e = '0;
    for (int r = 0; r < NumReps; r++) begin
      e[r*SeedWidth +: SeedWidth] = s;
    end
    return e;
  endfunction

  function automatic logic [HVDimension-1:0] ca90_step(input logic [HVDimension-1:0] cur);
    logic [HVDimension-1:0] nxt;
    nxt = '0;
    for (int i = 0; i < HVDimension; i++) begin
      nxt[i] = cur[(i + HVDimension - 1) % HVDimension] ^ cur[(i + 1) % HVDimension];
    end
    return nxt;
  endfunction

  function automatic logic [HVDimension-1:0] cim_mask(input logic [CimSelWidth-1:0] level);
    logic [HVDimension-1:0] m;
    m = '0;
    for (int i = 0; i < HVDimension; i++) begin
      m[i] = (i < 2 * int'(level));
    end
    return m;
  endfunction

  // Entries 0..NumImSets-1 are IM bank seeds; entry NumImSets is the CiM seed.
  logic [SeedWidth-1:0] seed_q [NumImSets+1];
  logic [NumPorts-1:0]  port_idle;

  assign seed_wr_ready_o = &port_idle;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i <= NumImSets; i++) begin
        seed_q[i] <= '0;
      end
    end else if (seed_wr_valid_i && seed_wr_ready_o && (32'(seed_wr_addr_i) <= NumImSets)) begin
      seed_q[seed_wr_addr_i] <= seed_wr_data_i;
    end
  end

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    state_e                 state_q, state_d;
    logic [HVDimension-1:0] work_q, work_d;
    logic [HVDimension-1:0] hv_q, hv_d;
    logic [RemWidth-1:0]    rem_q, rem_d;
    logic                   perr_q, perr_d;
    logic                   err_q, err_d;
    logic [StepWidth-1:0]   steps;
    logic [31:0]            bank_idx;
    logic [SeedWidth-1:0]   im_seed;
    logic [HVDimension-1:0] stage [UnrollFactor+1];

    assign stage[0] = work_q;
    for (genvar j = 0; j < UnrollFactor; j++) begin : g_unroll
      assign stage[j+1] = ca90_step(stage[j]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= S_IDLE;
        work_q  <= '0;
        hv_q    <= '0;
        rem_q   <= '0;
        perr_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        work_q  <= work_d;
        hv_q    <= hv_d;
        rem_q   <= rem_d;
        perr_q  <= perr_d;
        err_q   <= err_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      work_d   = work_q;
      hv_d     = hv_q;
      rem_d    = rem_q;
      perr_d   = perr_q;
      err_d    = err_q;
      bank_idx = 32'(req_addr_i[p]) / NumPerImBank;
      im_seed  = '0;
      if (bank_idx < NumImSets) begin
        im_seed = seed_q[SeedAddrWidth'(bank_idx)];
      end
      if (32'(rem_q) >= UnrollFactor) begin
        steps = StepWidth'(UnrollFactor);
      end else begin
        steps = StepWidth'(rem_q);
      end

      unique case (state_q)
        S_IDLE: begin
          if (req_valid_i[p]) begin
            state_d = S_GEN;
            work_d  = '0;
            rem_d   = '0;
            perr_d  = 1'b0;
            unique case (req_mode_i[p])
              2'd0: begin
                if (32'(req_addr_i[p]) >= NumTotIm) begin
                  perr_d = 1'b1;
                end else begin
                  work_d = expand(im_seed);
                  rem_d  = RemWidth'(32'(req_addr_i[p]) % NumPerImBank);
                end
              end
              2'd1: work_d = expand(seed_q[NumImSets]) ^ cim_mask(req_addr_i[p][CimSelWidth-1:0]);
              2'd2: work_d = '0;
              default: perr_d = 1'b1;
            endcase
          end
        end
        S_GEN: begin
          if (rem_q == '0) begin
            hv_d    = work_q;
            err_d   = perr_q;
            state_d = S_RESP;
          end else begin
            work_d = stage[steps];
            rem_d  = rem_q - RemWidth'(steps);
          end
        end
        S_RESP: begin
          // Returning to IDLE only; a new request waits for the following cycle.
          if (rsp_ready_i[p]) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    assign port_idle[p]   = (state_q == S_IDLE);
    assign req_ready_o[p] = (state_q == S_IDLE);
    assign rsp_valid_o[p] = (state_q == S_RESP);
    assign rsp_hv_o[p]    = hv_q;
    assign rsp_err_o[p]   = err_q;
  end

endmodule

// File: tb/tb_item_memory_seq.sv
// tb/tb_item_memory_seq.sv - self-checking bench for item_memory_seq
// Expected HVs come from a rotate-based CA90 model and a seed shadow array.
module tb_item_memory_seq;
  localparam int D = 512;
  localparam int SW = 32;
  localparam int U = 4;
  localparam int NTOT = 1024;
  localparam int NBANK = 128;
  localparam int NSETS = 8;
  localparam int AW = 10;
  localparam int SAW = 4;

  typedef logic [D-1:0] hv_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 seed_wr_valid, seed_wr_ready;
  logic [SAW-1:0]       seed_wr_addr;
  logic [31:0]          seed_wr_data;
  logic [1:0]           req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0][1:0]      req_mode;
  logic [1:0][AW-1:0]   req_addr;
  logic [1:0][D-1:0]    rsp_hv;

  logic                 b_seed_wr_valid, b_seed_wr_ready;
  logic [SAW-1:0]       b_seed_wr_addr;
  logic [31:0]          b_seed_wr_data;
  logic [0:0]           b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [0:0][1:0]      b_req_mode;
  logic [0:0][AW-1:0]   b_req_addr;
  logic [0:0][D-1:0]    b_rsp_hv;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] m_seed [NSETS+1];

  item_memory_seq #(.NumPorts(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .seed_wr_valid_i(seed_wr_valid), .seed_wr_ready_o(seed_wr_ready),
    .seed_wr_addr_i(seed_wr_addr), .seed_wr_data_i(seed_wr_data),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_mode_i(req_mode), .req_addr_i(req_addr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_hv_o(rsp_hv), .rsp_err_o(rsp_err)
  );

  item_memory_seq #(.NumTotIm(1000), .NumPerImBank(125), .NumPorts(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .seed_wr_valid_i(b_seed_wr_valid), .seed_wr_ready_o(b_seed_wr_ready),
    .seed_wr_addr_i(b_seed_wr_addr), .seed_wr_data_i(b_seed_wr_data),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .req_mode_i(b_req_mode), .req_addr_i(b_req_addr),
    .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready),
    .rsp_hv_o(b_rsp_hv), .rsp_err_o(b_rsp_err)
  );

  function automatic hv_t m_expand(input logic [31:0] s);
    hv_t h;
    for (int r = 0; r < D / SW; r++) h[r*SW +: SW] = s;
    return h;
  endfunction

  function automatic hv_t m_ca90(input hv_t c);
    return {c[D-2:0], c[D-1]} ^ {c[0], c[D-1:1]};
  endfunction

  function automatic hv_t m_mask(input int level);
    hv_t m = '0;
    for (int i = 0; i < 2 * level; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model(input logic [1:0] mode, input logic [AW-1:0] addr,
                       output hv_t hv, output logic err, output int lat);
    int bank, k;
    hv = '0; err = 1'b0; lat = 1;
    case (mode)
      2'd0: begin
        bank = int'(addr) / NBANK;
        k = int'(addr) % NBANK;
        hv = m_expand(m_seed[bank]);
        repeat (k) hv = m_ca90(hv);
        lat = 1 + (k + U - 1) / U;
      end
      2'd1: hv = m_expand(m_seed[NSETS]) ^ m_mask(int'(addr) % (D / 2));
      2'd2: hv = '0;
      default: err = 1'b1;
    endcase
  endtask

  task automatic seed_write(input logic [SAW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    n_cmp++;
    if (seed_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_wr_ready idle: got %b expected 1", seed_wr_ready);
    end
    seed_wr_valid = 1'b1; seed_wr_addr = a; seed_wr_data = d;
    @(posedge clk);
    @(negedge clk);
    seed_wr_valid = 1'b0;
    if (int'(a) <= NSETS) m_seed[a] = d;
  endtask

  task automatic issue(input int p, input logic [1:0] mode, input logic [AW-1:0] addr);
    @(negedge clk);
    n_cmp++;
    if (req_ready[p] !== 1'b1) begin
      n_fail++;
      $display("FAIL req_ready port%0d before issue: got %b expected 1", p, req_ready[p]);
    end
    req_valid[p] = 1'b1; req_mode[p] = mode; req_addr[p] = addr;
    @(posedge clk);
    @(negedge clk);
    req_valid[p] = 1'b0;
  endtask

  // Entered on the negedge right after the accepting edge.
  task automatic wait_rsp(input int p, input hv_t exp_hv, input logic exp_err,
                          input int exp_lat, input int hold, input string name);
    int lat = 0;
    while (rsp_valid[p] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (rsp_hv[p] !== exp_hv) begin
      n_fail++;
      $display("FAIL %s hv: got %h expected %h", name, rsp_hv[p], exp_hv);
    end
    n_cmp++;
    if (rsp_err[p] !== exp_err) begin
      n_fail++;
      $display("FAIL %s err: got %b expected %b", name, rsp_err[p], exp_err);
    end
    if (hold > 0) begin
      req_valid[p] = 1'b1; req_mode[p] = 2'd2; req_addr[p] = '0;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        n_cmp++;
        if (rsp_valid[p] !== 1'b1 || rsp_hv[p] !== exp_hv || req_ready[p] !== 1'b0) begin
          n_fail++;
          $display("FAIL %s hold cycle %0d: valid=%b ready=%b hv_ok=%b expected valid=1 ready=0 hv_ok=1",
                   name, c, rsp_valid[p], req_ready[p], rsp_hv[p] === exp_hv);
        end
      end
      req_valid[p] = 1'b0;
    end
    rsp_ready[p] = 1'b1;
    @(negedge clk);
    rsp_ready[p] = 1'b0;
    n_cmp++;
    if (rsp_valid[p] !== 1'b0 || req_ready[p] !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after handshake: valid=%b ready=%b expected valid=0 ready=1",
               name, rsp_valid[p], req_ready[p]);
    end
  endtask

  task automatic run_req(input int p, input logic [1:0] mode, input logic [AW-1:0] addr,
                         input string name);
    hv_t h; logic e; int l;
    model(mode, addr, h, e, l);
    issue(p, mode, addr);
    wait_rsp(p, h, e, l, 0, name);
  endtask

  task automatic test_reset;
    n_cmp++;
    if (req_ready !== 2'b11 || rsp_valid !== 2'b00 || rsp_err !== 2'b00 ||
        rsp_hv !== '0 || seed_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset state: ready=%b valid=%b err=%b hv_zero=%b swr=%b expected 11 00 00 1 1",
               req_ready, rsp_valid, rsp_err, rsp_hv === '0, seed_wr_ready);
    end
  endtask

  task automatic test_im_basic;
    hv_t p0, p1, h; logic e; int l;
    for (int i = 0; i < D; i++) begin
      p0[i] = (i % 32 == 0);
      p1[i] = (i % 32 == 1) || (i % 32 == 31);
    end
    seed_write(4'd0, 32'h0000_0001);
    issue(0, 2'd0, 10'd0);
    wait_rsp(0, p0, 1'b0, 1, 0, "im_addr0");
    issue(0, 2'd0, 10'd1);
    wait_rsp(0, p1, 1'b0, 2, 0, "im_addr1");
    model(2'd0, 10'd5, h, e, l);
    issue(0, 2'd0, 10'd5);
    wait_rsp(0, h, 1'b0, 3, 0, "im_addr5");
  endtask

  task automatic test_cim_zero;
    hv_t h;
    seed_write(4'd8, 32'hFFFF_FFFF);
    h = '1; h[5:0] = '0;
    issue(0, 2'd1, 10'd3);
    wait_rsp(0, h, 1'b0, 1, 0, "cim_level3");
    issue(1, 2'd1, 10'h300);
    wait_rsp(1, '1, 1'b0, 1, 0, "cim_level0_upper");
    issue(1, 2'd1, 10'd255);
    h = '0; h[D-1:D-2] = 2'b11;
    wait_rsp(1, h, 1'b0, 1, 0, "cim_level255");
    issue(0, 2'd2, 10'($urandom));
    wait_rsp(0, '0, 1'b0, 1, 0, "zero_mode");
  endtask

  task automatic test_err_b(input logic [AW-1:0] a, input logic exp_err, input int exp_lat,
                            input string name);
    int lat = 0;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_mode[0] = 2'd0; b_req_addr[0] = a;
    @(posedge clk);
    @(negedge clk);
    b_req_valid = 1'b0;
    while (b_rsp_valid[0] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat != exp_lat || b_rsp_err[0] !== exp_err || b_rsp_hv[0] !== '0) begin
      n_fail++;
      $display("FAIL %s: lat=%0d err=%b hv_zero=%b expected lat=%0d err=%b hv_zero=1",
               name, lat, b_rsp_err[0], b_rsp_hv[0] === '0, exp_lat, exp_err);
    end
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_rsp_ready = 1'b0;
  endtask

  task automatic test_errors;
    issue(1, 2'd3, 10'd17);
    wait_rsp(1, '0, 1'b1, 1, 0, "mode3");
    test_err_b(10'd1000, 1'b1, 1, "im_addr1000_ntot1000");
    test_err_b(10'd999, 1'b0, 32, "im_addr999_ntot1000");
  endtask

  task automatic test_parallel;
    hv_t h0, h1; logic e0, e1; int l0, l1;
    logic [31:0] d;
    seed_write(4'd1, 32'h8000_0000);
    model(2'd0, 10'd127, h0, e0, l0);
    model(2'd0, 10'd128, h1, e1, l1);
    d = $urandom;
    @(negedge clk);
    req_valid = 2'b11;
    req_mode[0] = 2'd0; req_addr[0] = 10'd127;
    req_mode[1] = 2'd0; req_addr[1] = 10'd128;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    fork
      wait_rsp(0, h0, 1'b0, 33, 0, "par_port0_im127");
      wait_rsp(1, m_expand(32'h8000_0000), 1'b0, 1, 0, "par_port1_im128");
      begin
        seed_wr_valid = 1'b1; seed_wr_addr = 4'd2; seed_wr_data = d;
        for (int c = 0; c < 20; c++) begin
          n_cmp++;
          if (seed_wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL seed_wr_ready busy cycle %0d: got %b expected 0", c, seed_wr_ready);
          end
          @(negedge clk);
        end
      end
    join
    n_cmp++;
    if (seed_wr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_wr_ready after idle: got %b expected 1", seed_wr_ready);
    end
    @(posedge clk);
    @(negedge clk);
    seed_wr_valid = 1'b0;
    m_seed[2] = d;
    run_req(1, 2'd0, 10'd256, "deferred_seed_im256");
    run_req(0, 2'd0, 10'd256 + 10'($urandom_range(1, 127)), "deferred_seed_bank2");
  endtask

  task automatic test_backpressure;
    hv_t h; logic e; int l;
    model(2'd0, 10'd5, h, e, l);
    issue(1, 2'd0, 10'd5);
    wait_rsp(1, h, e, l, 10, "backpressure");
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 0) seed_write(4'($urandom_range(0, 9)), $urandom);
      run_req($urandom_range(0, 1), 2'($urandom_range(0, 3)), 10'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    seed_write(4'd0, 32'hA5A5_0F0F);
    seed_write(4'd8, 32'h1234_5678);
    issue(0, 2'd0, 10'd127);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i <= NSETS; i++) m_seed[i] = '0;
    n_cmp++;
    if (rsp_valid !== 2'b00 || rsp_hv !== '0 || req_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL reset mid-gen: valid=%b ready=%b hv_zero=%b expected 00 11 1",
               rsp_valid, req_ready, rsp_hv === '0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL aborted op responded: got %0d valid cycles expected 0", seen);
    end
    run_req(0, 2'd0, 10'd127, "post_reset_im_seed0");
    run_req(1, 2'd1, 10'd0, "post_reset_cim_seed0");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    seed_wr_valid = 1'b0; seed_wr_addr = '0; seed_wr_data = '0;
    req_valid = '0; req_mode = '0; req_addr = '0; rsp_ready = '0;
    b_seed_wr_valid = 1'b0; b_seed_wr_addr = '0; b_seed_wr_data = '0;
    b_req_valid = '0; b_req_mode = '0; b_req_addr = '0; b_rsp_ready = '0;
    for (int i = 0; i <= NSETS; i++) m_seed[i] = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_im_basic();
    test_cim_zero();
    test_errors();
    test_parallel();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
